// File: rtl/wb_pkg.sv
// Shared Wishbone fetch definitions: bus widths, fetch state encoding, word stride.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_pkg;
    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_SEL_WIDTH  = 4;
    localparam int WORD_INC      = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2,
        HALT    = 2'd3
    } fetch_state_e;
endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO holding {address, data} words fetched ahead of the consumer.
// Latency: a push on edge N is visible at the head in cycle N+1; head is read from registered storage.
// Backpressure: caller must not push when full unless it pops in the same cycle; flush empties it on the next edge.
module prefetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = push_dat;
                wr_d        = wr_q + 1'b1;
            end
            if (pop) begin
                rd_d = rd_q + 1'b1;
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_dat = mem_q[rd_q];
    assign full     = (cnt_q == CW'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign count    = cnt_q;
endmodule

// File: rtl/wb_prefetch.sv
// Wishbone classic read master fetching sequential words into a small FIFO, with redirect/flush and sticky fault.
// Latency: first request one cycle after reset/redirect settles; a word acked on edge N is offered in cycle N+1.
// Backpressure: out_ready stalls the FIFO; fetching pauses when it would fill and resumes once an entry frees.
module wb_prefetch
    import wb_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADR  = '0
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    output logic                      wb_cyc,
    output logic                      wb_stb,
    output logic                      wb_we,
    output logic [WB_SEL_WIDTH-1:0]   wb_sel,
    output logic [ADDR_WIDTH-1:0]     wb_adr,
    output logic [WB_DATA_WIDTH-1:0]  wb_dat_w,
    input  logic [WB_DATA_WIDTH-1:0]  wb_dat_r,
    input  logic                      wb_ack,
    input  logic                      wb_err,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WB_DATA_WIDTH-1:0]  out_data,
    output logic [ADDR_WIDTH-1:0]     out_adr,
    input  logic                      redirect_valid,
    input  logic [ADDR_WIDTH-1:0]     redirect_adr,
    output logic                      fault,
    output logic [ADDR_WIDTH-1:0]     fault_adr
);
    localparam int                    CW        = $clog2(DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] ADR_MASK  = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] ADR_INC   = ADDR_WIDTH'(WORD_INC);
    localparam logic [ADDR_WIDTH-1:0] RESET_AL  = RESET_ADR & ADR_MASK;
    localparam logic [CW-1:0]         DEPTH_C   = CW'(DEPTH);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic                  cyc_q, cyc_d;
    logic                  fault_q, fault_d;
    logic [ADDR_WIDTH-1:0] fault_adr_q, fault_adr_d;

    logic                  push, pop, flush;
    logic                  fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_count, level_after;
    logic [ADDR_WIDTH+WB_DATA_WIDTH-1:0] head;

    prefetch_fifo #(
        .WIDTH (ADDR_WIDTH + WB_DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .push     (push),
        .push_dat ({adr_q, wb_dat_r}),
        .pop      (pop),
        .flush    (flush),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // A redirect flushes, so a pop in that cycle must not advance the read side.
    assign pop         = !fifo_empty && out_ready && !redirect_valid;
    assign level_after = pop ? fifo_count : fifo_count + CW'(1);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        adr_d       = adr_q;
        fault_d     = fault_q;
        fault_adr_d = fault_adr_q;
        push        = 1'b0;
        flush       = 1'b0;
        if (redirect_valid) begin
            flush   = 1'b1;
            ptr_d   = redirect_adr & ADR_MASK;
            fault_d = 1'b0;
            // An open cycle must still be allowed to complete; its response is dropped.
            if ((state_q == REQ || state_q == DISCARD) && !(wb_ack || wb_err)) begin
                state_d = DISCARD;
            end else begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_full) begin
                        state_d = REQ;
                        adr_d   = ptr_q;
                    end
                end
                REQ: begin
                    if (wb_err) begin
                        fault_d     = 1'b1;
                        fault_adr_d = adr_q;
                        state_d     = HALT;
                    end else if (wb_ack) begin
                        push  = 1'b1;
                        ptr_d = ptr_q + ADR_INC;
                        if (level_after < DEPTH_C) begin
                            adr_d = ptr_q + ADR_INC;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (wb_ack || wb_err) begin
                        state_d = IDLE;
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        cyc_d = (state_d == REQ) || (state_d == DISCARD);
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q     <= IDLE;
            ptr_q       <= RESET_AL;
            adr_q       <= RESET_AL;
            cyc_q       <= 1'b0;
            fault_q     <= 1'b0;
            fault_adr_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            adr_q       <= adr_d;
            cyc_q       <= cyc_d;
            fault_q     <= fault_d;
            fault_adr_q <= fault_adr_d;
        end
    end

    assign wb_cyc    = cyc_q;
    assign wb_stb    = cyc_q;
    assign wb_we     = 1'b0;
    assign wb_sel    = '1;
    assign wb_adr    = adr_q;
    assign wb_dat_w  = '0;
    assign out_valid = !fifo_empty;
    assign out_data  = head[WB_DATA_WIDTH-1:0];
    assign out_adr   = head[WB_DATA_WIDTH +: ADDR_WIDTH];
    assign fault     = fault_q;
    assign fault_adr = fault_adr_q;
endmodule
